spike_index_selector: RTL and testbench

SPIKE_INDEX_SELECTOR -- requirements
Module: spike_index_selector

---
 rtl/spike_sel_pkg.sv | 18 +
 rtl/spike_index_selector_if.sv | 27 ++
 rtl/spike_lane_scan.sv | 34 +++
 rtl/spike_index_selector.sv | 151 +++++++++++++++
 tb/tb_spike_index_selector.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_sel_pkg.sv
// Shared defaults, FSM state encoding and derived lane count for the spike index selector.
package spike_sel_pkg;

    localparam int DEF_N_PIXELS = 784;
    localparam int DEF_LANES    = 16;
    localparam int DEF_IDX_W    = 10;
    localparam int DEF_RAND_W   = 7;
    localparam int N_LANES      = DEF_N_PIXELS / DEF_LANES;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COUNT  = 3'd1,
        REDUCE = 3'd2,
        SELECT = 3'd3,
        FINISH = 3'd4
    } spike_sel_state_t;

endpackage

// File: rtl/spike_index_selector_if.sv
// Request/result bundle between a time-step controller (master) and the spike index selector (slave).
interface spike_index_selector_if
    import spike_sel_pkg::*;
#(
    parameter int N_PIXELS = DEF_N_PIXELS,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int RAND_W   = DEF_RAND_W
) ();
    logic                start;
    logic [N_PIXELS-1:0] spike_vec;
    logic [RAND_W-1:0]   rand_num;
    logic                lfsr_enable;
    logic                busy;
    logic                done;
    logic                spike_valid;
    logic [IDX_W-1:0]    spike_index;

    modport master (
        output start, spike_vec, rand_num,
        input  lfsr_enable, busy, done, spike_valid, spike_index
    );

    modport slave (
        input  start, spike_vec, rand_num,
        output lfsr_enable, busy, done, spike_valid, spike_index
    );
endinterface

// File: rtl/spike_lane_scan.sv
// Purpose: popcount of one lane plus offset of its n-th set bit (n counted from 0).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module spike_lane_scan
    import spike_sel_pkg::*;
#(
    parameter  int LANES = DEF_LANES,
    localparam int PW    = $clog2(LANES + 1),
    localparam int OW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0] lane,
    input  logic [PW-1:0]    n,
    output logic [PW-1:0]    pop,
    output logic [OW-1:0]    offset,
    output logic             hit
);

    // pop doubles as the running rank of the bit being examined
    always_comb begin
        pop    = '0;
        offset = '0;
        hit    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (lane[i]) begin
                if (!hit && pop == n) begin
                    hit    = 1'b1;
                    offset = OW'(i);
                end
                pop = pop + PW'(1);
            end
        end
    end

endmodule

// File: rtl/spike_index_selector.sv
// Purpose: pick one spiking pixel uniformly-ish by rand_num mod popcount; optional SPIKE_SEL_STATS_EN adds empty_steps.
// Latency: N_LANES count cycles + floor(rand/C) reduce cycles + lanes-to-hit select cycles + 1 finish cycle.
// Backpressure: start is accepted only in IDLE; requests while busy are dropped, not queued.
module spike_index_selector
    import spike_sel_pkg::*;
#(
    parameter int N_PIXELS = DEF_N_PIXELS,
    parameter int LANES    = DEF_LANES,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int RAND_W   = DEF_RAND_W
) (
    input  logic                  clk,
    input  logic                  reset,
    spike_index_selector_if.slave sel
`ifdef SPIKE_SEL_STATS_EN
    ,
    output logic [15:0]           empty_steps
`endif
);

    localparam int NL  = N_PIXELS / LANES;
    localparam int LPW = (NL > 1) ? $clog2(NL) : 1;
    localparam int CW  = IDX_W + 1;
    localparam int TW  = (RAND_W > CW) ? RAND_W : CW;
    localparam int PW  = $clog2(LANES + 1);
    localparam int OW  = (LANES > 1) ? $clog2(LANES) : 1;

    spike_sel_state_t    state, state_n;
    logic [N_PIXELS-1:0] vec_q, vec_n;
    logic [LPW-1:0]      lane_ptr, lane_ptr_n;
    logic [CW-1:0]       cnt, cnt_n, cnt_sum;
    logic [TW-1:0]       target, target_n, target_red;
    logic [IDX_W-1:0]    index_q, index_n, lane_base;
    logic                valid_q, valid_n;
    logic                lfsr_q, lfsr_n;

    logic [LANES-1:0]    lane_bits;
    logic [PW-1:0]       lane_pop, scan_n;
    logic [OW-1:0]       lane_off;
    logic                lane_hit;
    logic                last_lane;

    assign lane_base  = IDX_W'(lane_ptr) * IDX_W'(LANES);
    assign lane_bits  = vec_q[lane_base +: LANES];
    assign last_lane  = (lane_ptr == LPW'(NL - 1));
    assign cnt_sum    = cnt + CW'(lane_pop);
    assign target_red = target - TW'(cnt);
    // In SELECT, target is the rank still to skip; anything >= LANES cannot land in this lane
    assign scan_n     = (target >= TW'(LANES)) ? PW'(LANES) : PW'(target);

    spike_lane_scan #(.LANES(LANES)) u_scan (
        .lane   (lane_bits),
        .n      (scan_n),
        .pop    (lane_pop),
        .offset (lane_off),
        .hit    (lane_hit)
    );

    always_comb begin
        state_n    = state;
        vec_n      = vec_q;
        lane_ptr_n = lane_ptr;
        cnt_n      = cnt;
        target_n   = target;
        index_n    = index_q;
        valid_n    = valid_q;
        lfsr_n     = 1'b0;
        case (state)
            IDLE: begin
                if (sel.start) begin
                    vec_n      = sel.spike_vec;
                    target_n   = TW'(sel.rand_num);
                    valid_n    = 1'b0;
                    lfsr_n     = 1'b1;
                    cnt_n      = '0;
                    lane_ptr_n = '0;
                    state_n    = COUNT;
                end
            end
            COUNT: begin
                cnt_n = cnt_sum;
                if (last_lane) begin
                    lane_ptr_n = '0;
                    if (cnt_sum == '0)
                        state_n = FINISH;
                    else if (target < TW'(cnt_sum))
                        state_n = SELECT;
                    else
                        state_n = REDUCE;
                end else begin
                    lane_ptr_n = lane_ptr + LPW'(1);
                end
            end
            REDUCE: begin
                target_n = target_red;
                if (target_red < TW'(cnt))
                    state_n = SELECT;
            end
            SELECT: begin
                if (lane_hit) begin
                    index_n = lane_base + IDX_W'(lane_off);
                    valid_n = 1'b1;
                    state_n = FINISH;
                end else begin
                    target_n   = target - TW'(lane_pop);
                    lane_ptr_n = lane_ptr + LPW'(1);
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            vec_q    <= '0;
            lane_ptr <= '0;
            cnt      <= '0;
            target   <= '0;
            index_q  <= '0;
            valid_q  <= 1'b0;
            lfsr_q   <= 1'b0;
        end else begin
            state    <= state_n;
            vec_q    <= vec_n;
            lane_ptr <= lane_ptr_n;
            cnt      <= cnt_n;
            target   <= target_n;
            index_q  <= index_n;
            valid_q  <= valid_n;
            lfsr_q   <= lfsr_n;
        end
    end

    assign sel.busy        = (state != IDLE);
    assign sel.done        = (state == FINISH);
    assign sel.lfsr_enable = lfsr_q;
    assign sel.spike_valid = valid_q;
    assign sel.spike_index = index_q;

`ifdef SPIKE_SEL_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            empty_steps <= '0;
        else if (state == FINISH && cnt == '0 && empty_steps != 16'hFFFF)
            empty_steps <= empty_steps + 16'd1;
    end
`endif

endmodule

// File: tb/tb_spike_index_selector.sv
// Scoreboard bench for spike_index_selector: expected pick and latency queued at start, checked at done.
module tb_spike_index_selector;
    import spike_sel_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spike_index_selector_if sif ();

`ifdef SPIKE_SEL_STATS_EN
    logic [15:0] empty_steps;
    spike_index_selector dut (.clk(clk), .reset(reset), .sel(sif), .empty_steps(empty_steps));
`else
    spike_index_selector dut (.clk(clk), .reset(reset), .sel(sif));
`endif

    typedef struct {
        logic       valid;
        logic [9:0] idx;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         acc_edge = 0;
    int         lfsr_since_done = 0;
    int         lfsr_total = 0;
    int         done_total = 0;
    logic [9:0] last_idx = '0;

    always @(posedge clk) cyc++;

    // Reference pick: rank (rand mod C) among set bits, lowest index first
    function automatic exp_t model(input logic [783:0] v, input logic [6:0] r);
        exp_t e;
        int c = 0;
        int seen = 0;
        int tgt;
        int p = 0;
        for (int i = 0; i < 784; i++) if (v[i]) c++;
        if (c == 0) begin
            e.valid = 1'b0;
            e.idx   = last_idx;
            e.lat   = 49;
        end else begin
            tgt = int'(r) % c;
            for (int i = 0; i < 784; i++) begin
                if (v[i]) begin
                    if (seen == tgt) p = i;
                    seen++;
                end
            end
            e.valid  = 1'b1;
            e.idx    = p[9:0];
            e.lat    = 49 + int'(r) / c + p / 16 + 1;
            last_idx = p[9:0];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (sif.lfsr_enable) begin
                acc_edge = cyc;
                lfsr_since_done++;
                lfsr_total++;
            end
            if (sif.done) begin
                done_total++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got done=1 required no pending op");
                end else begin
                    mon_e = sb.pop_front();
                    checks++;
                    if (sif.spike_valid !== mon_e.valid) begin
                        failures++;
                        $display("FAIL spike_valid: got %0b required %0b", sif.spike_valid, mon_e.valid);
                    end
                    checks++;
                    if (sif.spike_index !== mon_e.idx) begin
                        failures++;
                        $display("FAIL spike_index: got %0d required %0d", sif.spike_index, mon_e.idx);
                    end
                    if ((cyc - acc_edge) !== mon_e.lat) begin
                        failures++;
                        $display("FAIL latency: got %0d required %0d", cyc - acc_edge, mon_e.lat);
                    end
                    checks++;
                    if (lfsr_since_done !== 1) begin
                        failures++;
                        $display("FAIL lfsr_pulses_per_op: got %0d required 1", lfsr_since_done);
                    end
                end
                lfsr_since_done = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [783:0] v, input logic [6:0] r);
        sif.spike_vec = v;
        sif.rand_num  = r;
        sif.start     = 1'b1;
        sb.push_back(model(v, r));
        tick();
        sif.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: pending=%0d required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        sif.start     = 1'b0;
        sif.spike_vec = '0;
        sif.rand_num  = '0;
        repeat (3) tick();
        checks += 5;
        if (sif.busy !== 1'b0)        begin failures++; $display("FAIL reset_busy: got %0b required 0", sif.busy); end
        if (sif.done !== 1'b0)        begin failures++; $display("FAIL reset_done: got %0b required 0", sif.done); end
        if (sif.lfsr_enable !== 1'b0) begin failures++; $display("FAIL reset_lfsr: got %0b required 0", sif.lfsr_enable); end
        if (sif.spike_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b required 0", sif.spike_valid); end
        if (sif.spike_index !== 10'd0) begin failures++; $display("FAIL reset_index: got %0d required 0", sif.spike_index); end
        reset    = 1'b0;
        last_idx = '0;
        tick();
    endtask

    task automatic test_all_zero();
        start_op('0, 7'd10);
        checks++;
        if (sif.busy !== 1'b1) begin failures++; $display("FAIL zero_busy: got %0b required 1", sif.busy); end
        wait_idle("all_zero", 200);
        checks++;
        if (sif.busy !== 1'b0) begin failures++; $display("FAIL zero_idle: got %0b required 0", sif.busy); end
`ifdef SPIKE_SEL_STATS_EN
        checks++;
        if (empty_steps !== 16'd1) begin failures++; $display("FAIL empty_steps: got %0d required 1", empty_steps); end
`endif
    endtask

    task automatic test_single_bit();
        logic [783:0] v = '0;
        v[500] = 1'b1;
        start_op(v, 7'd37);
        wait_idle("single_bit", 300);
    endtask

    task automatic test_three_bits();
        logic [783:0] v = '0;
        v[3] = 1'b1; v[17] = 1'b1; v[700] = 1'b1;
        start_op(v, 7'd4);
        checks++;
        if (sif.spike_valid !== 1'b0) begin failures++; $display("FAIL valid_clear_on_start: got %0b required 0", sif.spike_valid); end
        wait_idle("three_bits", 300);
        start_op(v, 7'd2);
        wait_idle("three_bits_no_reduce", 300);
    endtask

    task automatic test_ends();
        logic [783:0] v = '0;
        v[0] = 1'b1; v[783] = 1'b1;
        start_op(v, 7'd100);
        wait_idle("ends_100", 300);
        start_op(v, 7'd99);
        wait_idle("ends_99", 300);
    endtask

    task automatic test_reset_in_select();
        logic [783:0] v = '0;
        logic [783:0] w = '0;
        v[500] = 1'b1;
        w[3] = 1'b1; w[17] = 1'b1; w[700] = 1'b1;
        start_op(v, 7'd37);
        repeat (90) tick();
        reset = 1'b1;
        #1;
        checks += 4;
        if (sif.busy !== 1'b0)        begin failures++; $display("FAIL abort_busy: got %0b required 0", sif.busy); end
        if (sif.spike_valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %0b required 0", sif.spike_valid); end
        if (sif.done !== 1'b0)        begin failures++; $display("FAIL abort_done: got %0b required 0", sif.done); end
        if (sif.spike_index !== 10'd0) begin failures++; $display("FAIL abort_index: got %0d required 0", sif.spike_index); end
        sb.delete();
        lfsr_since_done = 0;
        last_idx        = '0;
        tick();
        reset = 1'b0;
        tick();
        start_op(w, 7'd4);
        wait_idle("after_abort", 300);
    endtask

    task automatic test_start_held();
        logic [783:0] v = '0;
        exp_t e;
        int   n_ops;
        int   t0;
        int   d0;
        v[3] = 1'b1; v[17] = 1'b1; v[700] = 1'b1;
        e     = model(v, 7'd4);
        n_ops = 199 / (e.lat + 1) + 1;
        for (int i = 0; i < n_ops; i++) sb.push_back(model(v, 7'd4));
        t0 = lfsr_total;
        d0 = done_total;
        sif.spike_vec = v;
        sif.rand_num  = 7'd4;
        sif.start     = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        sif.start = 1'b0;
        wait_idle("start_held", 400);
        repeat (60) tick();
        checks += 2;
        if (lfsr_total - t0 !== n_ops) begin failures++; $display("FAIL held_lfsr_count: got %0d required %0d", lfsr_total - t0, n_ops); end
        if (done_total - d0 !== n_ops) begin failures++; $display("FAIL held_done_count: got %0d required %0d", done_total - d0, n_ops); end
    endtask

    task automatic test_back_to_back();
        logic [783:0] v;
        for (int k = 0; k < 6; k++) begin
            v = '0;
            for (int j = 0; j < int'($urandom_range(1, 8)); j++) v[$urandom_range(0, 783)] = 1'b1;
            start_op(v, 7'($urandom_range(0, 127)));
            wait_idle("back_to_back", 500);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_single_bit();
        test_three_bits();
        test_ends();
        test_reset_in_select();
        test_start_held();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
